obi_burst_reader: RTL and testbench
===================================

# obi_burst_reader

Read-burst initiator for the core-side memory request interface (req/gnt/rvalid). It accepts a start address and word count, issues sequential word reads toward a RAM port or RAM multiplexer input, and returns the read data in order on a valid/ready stream. It is the requesting end of the same handshake that the RAM multiplexer answers. Typical uses are DMA-style copy engines and boot loaders that stream instruction RAM contents.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; a multiple of 8
- LEN_WIDTH, 16, width of the burst length in words
- MAX_OUTSTANDING, 2, maximum number of granted-but-unreturned reads; must be at least 1
- FIFO_DEPTH, 4, return-data buffer entries; must be a power of 2 and at least MAX_OUTSTANDING

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start_i  in  1  burst start strobe; sampled only in IDLE
- start_addr_i  in  ADDR_WIDTH  first byte address; the low log2(DATA_WIDTH/8) bits are forced to 0
- len_i  in  LEN_WIDTH  number of words to read
- abort_i  in  1  stop the burst; sampled in RUN
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle pulse on return to IDLE
- mem_req_o  out  1  read request
- mem_gnt_i  in  1  grant; may be combinational on mem_req_o
- mem_rvalid_i  in  1  read data valid
- mem_addr_o  out  ADDR_WIDTH  request address
- mem_we_o  out  1  constant 0
- mem_be_o  out  DATA_WIDTH/8  constant all ones
- mem_wdata_o  out  DATA_WIDTH  constant 0
- mem_rdata_i  in  DATA_WIDTH  read data; valid with mem_rvalid_i
- data_valid_o  out  1  stream data valid
- data_ready_i  in  1  stream consumer ready
- data_o  out  DATA_WIDTH  stream data (FIFO head)

## Operation
- State machine states are IDLE, RUN and DRAIN.
- IDLE to RUN: start_i=1 and len_i≠0. The block latches the address into addr_q and the length into remaining_q.
- IDLE with start_i=1 and len_i=0: the block stays in IDLE and pulses done_o in the next cycle. No request is issued.
- start_i is ignored outside IDLE.
- Request eligibility: mem_req_o=1 only when all of the following hold:
  - the state is RUN
  - remaining_q≠0
  - outstanding_q < MAX_OUTSTANDING
  - outstanding_q + fifo_count < FIFO_DEPTH (credit rule: the FIFO can never overflow)
- mem_addr_o is driven from addr_q.
- Once mem_req_o is asserted it stays high, and mem_addr_o stays stable, until mem_gnt_i=1. This holds even if abort_i arrives; the request is honoured.
- On a grant (mem_req_o & mem_gnt_i):
  - addr_q += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH
  - remaining_q -= 1
  - outstanding_q += 1
- On mem_rvalid_i: mem_rdata_i is written to the FIFO and outstanding_q -= 1. If a grant and an rvalid occur in the same cycle, outstanding_q is unchanged.
- mem_rvalid_i with outstanding_q=0 is a protocol violation. It is ignored: no FIFO write and no counter change.
- Data is returned in order. A pop happens on data_valid_o & data_ready_i. A simultaneous push and pop on a full or empty FIFO is legal.
- RUN to IDLE: remaining_q=0, outstanding_q=0 and the FIFO is empty. done_o pulses in that transition cycle.
- RUN to DRAIN: abort_i=1 with no request pending. If a request is pending, the transition happens in the cycle it is granted.
  - On entering DRAIN, remaining_q is cleared and the FIFO is flushed.
  - In DRAIN, returning rdata is discarded and data_valid_o=0.
- DRAIN to IDLE: outstanding_q=0. done_o pulses in that cycle.
- Reset values:
  - busy_o, done_o, mem_req_o and data_valid_o are 0.
  - mem_addr_o and data_o are 0.
  - All counters are 0, the FIFO is empty, and the state is IDLE.
- Reset mid-burst discards all state. Responses already in flight after reset are treated as protocol violations and ignored.

## Timing
- start_i in cycle N gives busy_o=1 and the earliest mem_req_o=1 in cycle N+1.
- mem_req_o and the counters are registered.
- The grant is evaluated in the same cycle as the request. The next request, at the incremented address, may follow in the next cycle.
- FIFO write is registered: an rvalid in cycle M gives the earliest data_valid_o=1 in cycle M+1.
- Against a responder with fixed 1-cycle rvalid latency, always-granting and with data_ready_i=1, with MAX_OUTSTANDING≥2 and FIFO_DEPTH≥4: sustained throughput is one word per cycle.
- A burst of L words then completes with done_o at start+L+3 cycles.
- data_valid_o and data_o hold stable while data_ready_i=0.

## Test plan
- Basic burst: start_addr 0x100, len 4, gnt=1, rvalid one cycle after grant, ready=1 -> requests at 0x100, 0x104, 0x108 and 0x10C in consecutive cycles; data out in the same order; one done_o pulse; busy_o falls with it.
- Grant stall: hold gnt=0 for 3 cycles on the second request -> mem_req_o and mem_addr_o=0x104 held stable throughout; no duplicate or skipped address.
- Backpressure: FIFO_DEPTH 4, len 10, ready=0 -> requests stop once outstanding+count=4. Releasing ready resumes them; all 10 words delivered in order with no overflow.
- Zero length and wrap: len 0 -> done_o the next cycle with no request. Then addr 0xFFFFFFF8, len 3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Abort: len 8, abort_i after 3 grants while a request is pending -> that request completes, state enters DRAIN, outstanding data is discarded, data_valid_o=0, done_o fires once outstanding reaches 0.
- Reset mid-burst: assert rst_n=0 with 2 reads outstanding -> all outputs 0 immediately. After release, stray rvalids are ignored and a new burst runs correctly.

Source files
------------

// File: rtl/obi_burst_reader.sv
// obi_burst_reader: sequential word-read burst initiator on req/gnt/rvalid, returning data in order on a valid/ready stream
// Ports: clk, rst_n (async, active-low); start_i/start_addr_i/len_i/abort_i burst control; busy_o/done_o status;
//        mem_* request side (read-only: we=0, be=all ones, wdata=0); data_valid_o/data_ready_i/data_o return stream.
module obi_burst_reader #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic [DATA_WIDTH-1:0]   data_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEP = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [CW-1:0]           out_q, out_d, cnt_q, cnt_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic                    req_q, req_d, abort_q, abort_d, zl_q, zl_d;
    logic                    gnt, rv, push, pop, abort;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign busy_o       = state_q != IDLE;
    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign mem_we_o     = 1'b0;
    assign mem_be_o     = '1;
    assign mem_wdata_o  = '0;
    assign data_valid_o = cnt_q != '0;
    assign data_o       = data_valid_o ? mem[rptr_q] : '0;

    always_comb begin
        gnt     = req_q & mem_gnt_i;
        // rvalid with nothing outstanding is a protocol violation and is dropped
        rv      = mem_rvalid_i & (out_q != '0);
        push    = rv & (state_q == RUN);
        pop     = data_valid_o & data_ready_i;
        // an abort seen while a request waits for its grant is remembered until that grant
        abort   = abort_i | abort_q;
        state_d = state_q;
        addr_d  = gnt ? addr_q + STEP : addr_q;
        rem_d   = gnt ? rem_q - LEN_WIDTH'(1) : rem_q;
        out_d   = out_q + CW'(gnt) - CW'(rv);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wptr_d  = push ? nxt(wptr_q) : wptr_q;
        rptr_d  = pop ? nxt(rptr_q) : rptr_q;
        abort_d = abort_q;
        zl_d    = 1'b0;
        done_o  = zl_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start_i && len_i != '0) begin
                    state_d = RUN;
                    addr_d  = start_addr_i & ~ADDR_WIDTH'(BW - 1);
                    rem_d   = len_i;
                end else if (start_i) begin
                    zl_d = 1'b1;
                end
            end
            RUN: begin
                if (rem_q == '0 && out_q == '0 && cnt_q == '0) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end else if (abort && (!req_q || mem_gnt_i)) begin
                    state_d = DRAIN;
                    rem_d   = '0;
                    cnt_d   = '0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    abort_d = 1'b0;
                end else begin
                    abort_d = abort;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // a pending request is held until granted; a new one needs credit for its return slot
        req_d = (req_q & ~mem_gnt_i) |
                (state_d == RUN && rem_d != '0 && out_d < MAXO && out_d + cnt_d < DEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            req_q   <= 1'b0;
            abort_q <= 1'b0;
            zl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            req_q   <= req_d;
            abort_q <= abort_d;
            zl_q    <= zl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= mem_rdata_i;
    end
endmodule

// File: tb/tb_obi_burst_reader.sv
// tb_obi_burst_reader: randomized bench for obi_burst_reader against a transaction-level reference model
module tb_obi_burst_reader;
    localparam int AW = 32, DW = 32, LW = 16, MO = 2, FD = 4, BW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start_i = 1'b0, abort_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, mem_req_o, mem_we_o, data_valid_o;
    logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, data_ready_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i = '0, data_o;

    obi_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                       .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_addr_i(start_addr_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .data_o(data_o)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} ph_t;

    int n_vec = 0, n_err = 0, cyc = 0;
    // reference model: phase, next expected address, words still to request, reads in flight, expected stream
    ph_t           ph = M_IDLE;
    logic [AW-1:0] exp_addr = '0;
    int            left = 0, outs = 0;
    bit            zl = 0, ab_l = 0;
    logic [DW-1:0] exp_q[$];
    // responder: in-order read returns with a due cycle each
    logic [DW-1:0] rsp_d[$];
    int            rsp_t[$];
    int            last_due = 0;
    // stimulus knobs and bookkeeping
    int            gnt_pct = 100, rdy_pct = 100, abort_pct = 0, lat_min = 1, lat_max = 1;
    int            stall_idx = -1, stall_left = 0, abort_idx = -1;
    bit            ab_sent = 0, st_go = 0, prev_hold = 0;
    logic [AW-1:0] st_addr = '0, prev_addr = '0;
    int            st_len = 0, ngr_burst = 0, nreq_burst = 0, total_req = 0, npop = 0;
    int            done_cnt = 0, last_done_cyc = 0, start_cyc = 0;
    logic [AW-1:0] gaddr[$];
    int            gcyc[$];
    int            p0, r0, d0, k;
    logic [AW-1:0] lit[4];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic step();
        bit   elig, dexp, g, r, p, zl_n, to_drain;
        ph_t  nph;
        int   due;
        @(negedge clk);
        cyc++;
        elig = ph == M_RUN && left > 0 && outs < MO && outs + exp_q.size() < FD;
        dexp = (ph == M_RUN && left == 0 && outs == 0 && exp_q.size() == 0) ||
               (ph == M_DRAIN && outs == 0) || zl;
        chk("req", mem_req_o, elig);
        if (mem_req_o) chk("addr", mem_addr_o, exp_addr);
        if (prev_hold) begin
            chk("hold_req", mem_req_o, 1);
            chk("hold_addr", mem_addr_o, prev_addr);
        end
        chk("busy", busy_o, ph != M_IDLE);
        chk("done", done_o, dexp);
        chk("valid", data_valid_o, exp_q.size() != 0);
        if (data_valid_o && exp_q.size() != 0) chk("data", data_o, exp_q[0]);
        chk("const", {mem_we_o, mem_be_o, mem_wdata_o}, {1'b0, 4'hF, 32'h0});
        if (done_o) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (mem_req_o) begin
            total_req++;
            nreq_burst++;
        end
        // drive this cycle's inputs
        if (st_go) begin
            start_i = 1'b1;
            start_addr_i = st_addr;
            len_i = st_len[LW-1:0];
            st_go = 0;
            start_cyc = cyc;
        end else start_i = 1'b0;
        mem_gnt_i = $urandom_range(99) < gnt_pct;
        if (mem_req_o && ngr_burst == stall_idx && stall_left > 0) begin
            mem_gnt_i = 1'b0;
            stall_left--;
        end
        abort_i = ph == M_RUN && $urandom_range(99) < abort_pct;
        if (abort_idx >= 0 && ngr_burst == abort_idx && mem_req_o && !ab_sent && ph == M_RUN) begin
            abort_i = 1'b1;
            ab_sent = 1;
        end
        mem_rvalid_i = rsp_t.size() > 0 && rsp_t[0] <= cyc;
        if (mem_rvalid_i) begin
            mem_rdata_i = rsp_d.pop_front();
            void'(rsp_t.pop_front());
        end else mem_rdata_i = $urandom;
        data_ready_i = $urandom_range(99) < rdy_pct;
        // advance the model by this cycle's events
        g = mem_req_o && mem_gnt_i;
        r = mem_rvalid_i && outs > 0;
        p = data_valid_o && data_ready_i;
        zl_n = ph == M_IDLE && start_i && len_i == 0;
        to_drain = 0;
        nph = ph;
        if (ph == M_IDLE && start_i && len_i != 0) begin
            nph = M_RUN;
            exp_addr = start_addr_i & 32'hFFFF_FFFC;
            left = len_i;
            ab_l = 0;
            ngr_burst = 0;
            nreq_burst = 0;
            gaddr.delete();
            gcyc.delete();
        end else if (ph == M_RUN) begin
            if (dexp) nph = M_IDLE;
            else if ((abort_i || ab_l) && (!mem_req_o || g)) to_drain = 1;
            else if (abort_i) ab_l = 1;
        end else if (ph == M_DRAIN && outs == 0) nph = M_IDLE;
        if (g) begin
            gaddr.push_back(exp_addr);
            gcyc.push_back(cyc);
            exp_addr += BW;
            left--;
            outs++;
            ngr_burst++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_t.push_back(due);
            rsp_d.push_back($urandom);
        end
        if (r) begin
            outs--;
            if (ph == M_RUN) exp_q.push_back(mem_rdata_i);
        end
        if (p && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            npop++;
        end
        if (to_drain) begin
            nph = M_DRAIN;
            exp_q.delete();
            left = 0;
            ab_l = 0;
        end
        ph = nph;
        zl = zl_n;
        prev_hold = mem_req_o && !mem_gnt_i;
        prev_addr = mem_addr_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {busy_o, done_o, mem_req_o, data_valid_o, mem_addr_o, data_o}, '0);
        start_i = 0; abort_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        ph = M_IDLE; outs = 0; left = 0; zl = 0; ab_l = 0; prev_hold = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input int l);
        st_go = 1;
        st_addr = a;
        st_len = l;
    endtask

    task automatic wait_done(input int limit);
        int dd = done_cnt;
        int i = 0;
        while (done_cnt == dd && i < limit) begin
            step();
            i++;
        end
        if (done_cnt == dd) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done_o within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    task automatic chk_addrs(input string nm, input int n);
        chk({nm, "_count"}, gaddr.size(), n);
        for (int i = 0; i < n && i < gaddr.size(); i++) chk(nm, gaddr[i], lit[i]);
    endtask

    initial begin
        do_reset();
        repeat (2) step();
        // basic burst: back-to-back requests, done at start+L+3
        lit = '{32'h100, 32'h104, 32'h108, 32'h10C};
        p0 = npop; d0 = done_cnt;
        start_burst(32'h100, 4);
        wait_done(50);
        chk_addrs("basic_addr", 4);
        chk("basic_latency", last_done_cyc - start_cyc, 7);
        if (gcyc.size() == 4) chk("basic_b2b", gcyc[3] - gcyc[0], 3);
        chk("basic_pops", npop - p0, 4);
        repeat (3) step();
        chk("basic_one_done", done_cnt - d0, 1);
        // grant stall on the second request
        stall_idx = 1; stall_left = 3;
        start_burst(32'h100, 4);
        wait_done(50);
        chk_addrs("stall_addr", 4);
        chk("stall_req_cycles", nreq_burst, 7);
        stall_idx = -1;
        repeat (2) step();
        // backpressure: credits stop requests at outstanding+count=4
        rdy_pct = 0;
        p0 = npop;
        start_burst(32'h200, 10);
        repeat (20) step();
        chk("bp_grants", ngr_burst, 4);
        chk("bp_valid", data_valid_o, 1);
        rdy_pct = 100;
        wait_done(100);
        chk("bp_pops", npop - p0, 10);
        repeat (2) step();
        // zero length then address wrap
        r0 = total_req;
        start_burst(32'h300, 0);
        wait_done(5);
        chk("zl_latency", last_done_cyc - start_cyc, 1);
        chk("zl_noreq", total_req - r0, 0);
        step();
        lit = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0};
        start_burst(32'hFFFF_FFF8, 3);
        wait_done(30);
        chk_addrs("wrap_addr", 3);
        repeat (2) step();
        // abort while the fourth request waits for its grant
        lat_min = 1; lat_max = 3;
        stall_idx = 3; stall_left = 3; abort_idx = 3; ab_sent = 0;
        d0 = done_cnt;
        start_burst(32'h400, 8);
        wait_done(100);
        chk("abort_sent", ab_sent, 1);
        chk("abort_grants", ngr_burst, 4);
        stall_idx = -1; abort_idx = -1;
        repeat (3) step();
        chk("abort_one_done", done_cnt - d0, 1);
        // reset with two reads in flight, stray returns afterwards
        lat_min = 3; lat_max = 3;
        start_burst(32'h500, 8);
        k = 0;
        while (outs != 2 && k < 20) begin
            step();
            k++;
        end
        chk("rst_outstanding", outs, 2);
        chk("rst_stray_pending", rsp_t.size() != 0, 1);
        do_reset();
        k = 0;
        while (rsp_t.size() > 0 && k < 20) begin
            step();
            k++;
        end
        repeat (2) step();
        lat_min = 1; lat_max = 1;
        lit = '{32'h600, 32'h604, 32'h608, 32'h60C};
        p0 = npop;
        start_burst(32'h600, 4);
        wait_done(50);
        chk_addrs("post_rst_addr", 4);
        chk("post_rst_pops", npop - p0, 4);
        // randomized bursts
        for (int b = 0; b < 30; b++) begin
            gnt_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
            lat_max = $urandom_range(4, 1);
            lat_min = 1;
            abort_pct = ($urandom_range(3) == 0) ? 5 : 0;
            start_burst($urandom, $urandom_range(24, 1));
            wait_done(3000);
            abort_pct = 0;
            repeat ($urandom_range(3)) step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
